enc: RTL and testbench

// - Iterative encryptor for the 36-bit block cipher; forward direction matching decryptor `dec`.
// - Accepts a plaintext block and a 16-bit key. Runs ROUNDS generalized-Feistel rounds, one per clock, and presents the ciphertext.
// - Sits beside the shared key_gen and sbox instances in the encryption top level; drives their inputs and consumes their outputs.

---
 rtl/enc.sv | 139 +++++++++++++
 tb/tb_enc.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc.sv
// enc: iterative encryptor for the 36-bit generalized-Feistel block cipher.
// One round per clock. Round keys and S-box results come from the shared
// key_gen and sbox instances, which are combinational.
// Optional build macro: ENC_WHITEN_EN (pre-round key whitening on accept).
module enc #(
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         encrypt_en,
  input  logic [35:0]  S_I,
  input  logic [15:0]  keyin,
  output logic [143:0] key,
  output logic [6:0]   round_no,
  input  logic [8:0]   round_key_1,
  input  logic [8:0]   round_key_2,
  input  logic [8:0]   round_key_3,
  output logic [8:0]   sboxip_1,
  output logic [8:0]   sboxip_2,
  output logic [8:0]   sboxip_3,
  input  logic [8:0]   sboxop_1,
  input  logic [8:0]   sboxop_2,
  input  logic [8:0]   sboxop_3,
  output logic [35:0]  S_j,
  output logic         busy,
  output logic         done
);

  localparam logic [6:0] LP_ROUNDS = 7'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t        r_fsm;
  fsm_t        w_fsmNext;
  logic [35:0] r_state;
  logic [35:0] w_stateNext;
  logic [15:0] r_key;
  logic [15:0] w_keyNext;
  logic [6:0]  r_rnd;
  logic [6:0]  w_rndNext;
  logic [35:0] r_sj;
  logic [35:0] w_sjNext;
  logic        r_done;
  logic        w_doneNext;

  logic [8:0]  w_w0;
  logic [8:0]  w_w1;
  logic [8:0]  w_w2;
  logic [8:0]  w_w3;
  logic [35:0] w_roundOut;
  logic [35:0] w_loadValue;

  assign w_w0 = r_state[35:27];
  assign w_w1 = r_state[26:18];
  assign w_w2 = r_state[17:9];
  assign w_w3 = r_state[8:0];

  // S-box inputs follow the live state in every FSM state, not only in RUN.
  assign sboxip_1 = w_w0 ^ round_key_1;
  assign sboxip_2 = w_w1 ^ round_key_2;
  assign sboxip_3 = w_w2 ^ round_key_3;

  // One Feistel round: each word absorbs its neighbour's S-box output, W0 rotates to W3.
  assign w_roundOut = {w_w1 ^ sboxop_1, w_w2 ^ sboxop_2, w_w3 ^ sboxop_3, w_w0};

`ifdef ENC_WHITEN_EN
  // Key whitening folds the raw key into the low 16 bits before round 1.
  assign w_loadValue = S_I ^ {20'b0, keyin};
`else
  assign w_loadValue = S_I;
`endif

  assign key      = {128'b0, r_key};
  assign round_no = (r_fsm == RUN) ? r_rnd : 7'd0;
  assign busy     = (r_fsm != IDLE);
  assign done     = r_done;
  assign S_j      = r_sj;

  // State register for FSM, datapath, key latch, round counter and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= 36'd0;
      r_key   <= 16'd0;
      r_rnd   <= 7'd0;
      r_sj    <= 36'd0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsmNext;
      r_state <= w_stateNext;
      r_key   <= w_keyNext;
      r_rnd   <= w_rndNext;
      r_sj    <= w_sjNext;
      r_done  <= w_doneNext;
    end
  end

  // Next-state logic: start only from IDLE, run ROUNDS rounds, pulse done for one cycle.
  always_comb begin
    w_fsmNext   = r_fsm;
    w_stateNext = r_state;
    w_keyNext   = r_key;
    w_rndNext   = r_rnd;
    w_sjNext    = r_sj;
    w_doneNext  = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (encrypt_en) begin
          w_fsmNext   = RUN;
          w_stateNext = w_loadValue;
          w_keyNext   = keyin;
          w_rndNext   = 7'd1;
        end
      end
      RUN: begin
        w_stateNext = w_roundOut;
        if (r_rnd == LP_ROUNDS) begin
          w_sjNext   = w_roundOut;
          w_doneNext = 1'b1;
          w_fsmNext  = DONE;
          w_rndNext  = 7'd0;
        end else begin
          w_rndNext = r_rnd + 7'd1;
        end
      end
      DONE: begin
        w_fsmNext = IDLE;
      end
      default: begin
        w_fsmNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_enc.sv
// tb_enc: self-checking bench for enc with an identity S-box and a key_gen
// stub that returns constant round keys. Expected ciphertexts are queued
// on each start and popped when done is seen.
module tb_enc;

  localparam int ROUNDS_TB = 4;
`ifdef ENC_WHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         encrypt_en;
  logic [35:0]  S_I;
  logic [15:0]  keyin;
  logic [143:0] key;
  logic [6:0]   round_no;
  logic [8:0]   round_key_1;
  logic [8:0]   round_key_2;
  logic [8:0]   round_key_3;
  logic [8:0]   sboxip_1;
  logic [8:0]   sboxip_2;
  logic [8:0]   sboxip_3;
  logic [8:0]   sboxop_1;
  logic [8:0]   sboxop_2;
  logic [8:0]   sboxop_3;
  logic [35:0]  S_j;
  logic         busy;
  logic         done;

  logic [8:0]   kConst0;
  logic [8:0]   kConst1;
  logic [8:0]   kConst2;

  int checks = 0;
  int errors = 0;
  logic [35:0] expQ[$];

  enc #(.ROUNDS(ROUNDS_TB)) dut (
    .clk(clk), .rst_n(rst_n), .encrypt_en(encrypt_en), .S_I(S_I), .keyin(keyin),
    .key(key), .round_no(round_no),
    .round_key_1(round_key_1), .round_key_2(round_key_2), .round_key_3(round_key_3),
    .sboxip_1(sboxip_1), .sboxip_2(sboxip_2), .sboxip_3(sboxip_3),
    .sboxop_1(sboxop_1), .sboxop_2(sboxop_2), .sboxop_3(sboxop_3),
    .S_j(S_j), .busy(busy), .done(done)
  );

  // Stubs for the shared key_gen (constant keys) and sbox (identity).
  assign round_key_1 = kConst0;
  assign round_key_2 = kConst1;
  assign round_key_3 = kConst2;
  assign sboxop_1    = sboxip_1;
  assign sboxop_2    = sboxip_2;
  assign sboxop_3    = sboxip_3;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cipher with the stubbed key_gen and sbox folded in.
  function automatic logic [35:0] encModel(input logic [35:0] s, input logic [15:0] kin,
                                           input logic [8:0] k0, input logic [8:0] k1,
                                           input logic [8:0] k2);
    logic [8:0] a, b, c, d, t0, t1, t2;
    logic [35:0] x;
    x = WHITEN ? (s ^ {20'b0, kin}) : s;
    a = x[35:27]; b = x[26:18]; c = x[17:9]; d = x[8:0];
    for (int r = 0; r < ROUNDS_TB; r++) begin
      t0 = a ^ k0;
      t1 = b ^ k1;
      t2 = c ^ k2;
      {a, b, c, d} = {b ^ t0, c ^ t1, d ^ t2, a};
    end
    return {a, b, c, d};
  endfunction

  // Present a block, raise encrypt_en across the accept edge, queue its result.
  task automatic applyStimulus(input logic [35:0] s, input logic [15:0] kin, input bit holdEn);
    @(negedge clk);
    S_I        = s;
    keyin      = kin;
    encrypt_en = 1'b1;
    expQ.push_back(encModel(s, kin, kConst0, kConst1, kConst2));
    @(negedge clk);
    if (!holdEn) encrypt_en = 1'b0;
  endtask

  // Wait (bounded) until done is observed; n counts edges after the accept edge.
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; encrypt_en = 1'b0; S_I = 36'd0; keyin = 16'd0;
    kConst0 = 9'd0; kConst1 = 9'd0; kConst2 = 9'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({S_j, key, round_no, busy, done} !== 189'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got S_j=%h key=%h rn=%0d busy=%b done=%b exp all zero",
               S_j, key, round_no, busy, done);
    end
    checks++;
    if ({sboxip_1, sboxip_2, sboxip_3} !== 27'd0) begin
      errors++;
      $display("[TB] FAIL reset_sboxip got %h exp 0", {sboxip_1, sboxip_2, sboxip_3});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [35:0] expv;
    int n, busyCnt;
    bit badRn;
    kConst0 = 9'd0; kConst1 = 9'd0; kConst2 = 9'd0;
    applyStimulus({9'd1, 9'd2, 9'd4, 9'd8}, 16'h0000, 1'b0);
    n = 0; busyCnt = 0; badRn = 1'b0;
    while (!done && n < 100) begin
      if (busy) busyCnt++;
      if (round_no !== 7'(n + 1)) badRn = 1'b1;
      @(negedge clk);
      n++;
    end
    if (busy) busyCnt++;
    checks++;
    if (n != ROUNDS_TB) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d exp %0d", n, ROUNDS_TB);
    end
    checks++;
    if (badRn) begin
      errors++;
      $display("[TB] FAIL basic_round_no got wrong sequence exp 1..%0d", ROUNDS_TB);
    end
    checks++;
    if (round_no !== 7'd0) begin
      errors++;
      $display("[TB] FAIL basic_round_no_done got %0d exp 0", round_no);
    end
    expv = (expQ.size() > 0) ? expQ.pop_front() : 36'hX;
    checks++;
    if (S_j !== expv) begin
      errors++;
      $display("[TB] FAIL basic_model got %h exp %h", S_j, expv);
    end
    checks++;
    if (S_j !== {9'd8, 9'd9, 9'd11, 9'd15}) begin
      errors++;
      $display("[TB] FAIL basic_vector got %h exp %h", S_j, {9'd8, 9'd9, 9'd11, 9'd15});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
    checks++;
    if (busyCnt != ROUNDS_TB + 1) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles got %0d exp %0d", busyCnt, ROUNDS_TB + 1);
    end
  endtask

  task automatic test_roundkey();
    logic [35:0] expv;
    logic [15:0] kin;
    int n;
    kConst0 = 9'd1; kConst1 = 9'd1; kConst2 = 9'd1;
    kin = 16'($urandom);
    applyStimulus(36'd0, kin, 1'b0);
    checks++;
    if (key !== {128'b0, kin}) begin
      errors++;
      $display("[TB] FAIL rk_key got %h exp %h", key, {128'b0, kin});
    end
    waitDone(n);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL rk_timeout got %0d cycles exp %0d", n, ROUNDS_TB);
    end
    expv = (expQ.size() > 0) ? expQ.pop_front() : 36'hX;
    checks++;
    if (S_j !== expv) begin
      errors++;
      $display("[TB] FAIL rk_result got %h exp %h", S_j, expv);
    end
    checks++;
    if ({sboxip_1, sboxip_2, sboxip_3} !== {expv[35:27] ^ 9'd1, expv[26:18] ^ 9'd1, expv[17:9] ^ 9'd1}) begin
      errors++;
      $display("[TB] FAIL rk_sboxip got %h exp %h", {sboxip_1, sboxip_2, sboxip_3},
               {expv[35:27] ^ 9'd1, expv[26:18] ^ 9'd1, expv[17:9] ^ 9'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_whitening();
    logic [35:0] expv;
    logic [35:0] constv;
    int n;
    kConst0 = 9'd0; kConst1 = 9'd0; kConst2 = 9'd0;
    constv = WHITEN ? {9'd1, 9'd1, 9'd1, 9'd1} : 36'd0;
    applyStimulus(36'd0, 16'h0001, 1'b0);
    waitDone(n);
    expv = (expQ.size() > 0) ? expQ.pop_front() : 36'hX;
    checks++;
    if (n >= 100 || S_j !== expv || S_j !== constv) begin
      errors++;
      $display("[TB] FAIL whiten got %h after %0d exp %h", S_j, n, constv);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [35:0] expv, firstRes;
    logic [35:0] sA, sB;
    logic [15:0] kA, kB;
    int n;
    kConst0 = 9'h0A5; kConst1 = 9'h13C; kConst2 = 9'h077;
    sA = {4'h0, 32'($urandom)} ^ 36'h9_0000_0000;
    sB = {4'h0, 32'($urandom)};
    kA = 16'h1234; kB = 16'hBEEF;
    applyStimulus(sA, kA, 1'b1);
    n = 0;
    while (!done && n < 100) begin
      encrypt_en = ~encrypt_en;
      keyin      = kB;
      S_I        = sB;
      @(negedge clk);
      n++;
    end
    encrypt_en = 1'b1;
    checks++;
    if (key !== {128'b0, kA}) begin
      errors++;
      $display("[TB] FAIL b2b_key_stable got %h exp %h", key, {128'b0, kA});
    end
    expv = (expQ.size() > 0) ? expQ.pop_front() : 36'hX;
    firstRes = expv;
    checks++;
    if (n >= 100 || S_j !== expv) begin
      errors++;
      $display("[TB] FAIL b2b_first got %h after %0d exp %h", S_j, n, expv);
    end
    expQ.push_back(encModel(sB, kB, kConst0, kConst1, kConst2));
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap got busy=%b exp 0", busy);
    end
    @(negedge clk);
    encrypt_en = 1'b0;
    checks++;
    if (busy !== 1'b1 || round_no !== 7'd1 || key !== {128'b0, kB}) begin
      errors++;
      $display("[TB] FAIL b2b_restart got busy=%b rn=%0d key=%h exp 1 1 %h", busy, round_no, key, kB);
    end
    checks++;
    if (S_j !== firstRes) begin
      errors++;
      $display("[TB] FAIL b2b_sj_held got %h exp %h", S_j, firstRes);
    end
    waitDone(n);
    expv = (expQ.size() > 0) ? expQ.pop_front() : 36'hX;
    checks++;
    if (n >= 100 || S_j !== expv) begin
      errors++;
      $display("[TB] FAIL b2b_second got %h after %0d exp %h", S_j, n, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    logic [35:0] expv;
    int n;
    bit sawDone;
    kConst0 = 9'd0; kConst1 = 9'd0; kConst2 = 9'd0;
    applyStimulus({9'd3, 9'd5, 9'd7, 9'd9}, 16'h00F0, 1'b0);
    @(negedge clk);
    checks++;
    if (round_no !== 7'd2) begin
      errors++;
      $display("[TB] FAIL rst_mid_round got %0d exp 2", round_no);
    end
    rst_n = 1'b0;
    void'(expQ.pop_back());
    #1;
    checks++;
    if ({S_j, key, round_no, busy, done, sboxip_1, sboxip_2, sboxip_3} !== 216'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs got S_j=%h key=%h rn=%0d busy=%b done=%b exp all zero",
               S_j, key, round_no, busy, done);
    end
    sawDone = 1'b0;
    for (int i = 0; i < ROUNDS_TB + 2; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      errors++;
      $display("[TB] FAIL rst_mid_no_done got done pulse exp none");
    end
    applyStimulus({9'h1FF, 9'h000, 9'h155, 9'h0AA}, 16'h8001, 1'b0);
    waitDone(n);
    expv = (expQ.size() > 0) ? expQ.pop_front() : 36'hX;
    checks++;
    if (n != ROUNDS_TB || S_j !== expv) begin
      errors++;
      $display("[TB] FAIL rst_mid_rerun got %h after %0d exp %h after %0d", S_j, n, expv, ROUNDS_TB);
    end
    @(negedge clk);
  endtask

  // Absolute time limit so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no completion exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_basic();
    test_roundkey();
    test_whitening();
    test_back_to_back();
    test_reset_midrun();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d left exp 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
